// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and defaults for the writeback port arbiter and its load buffer.
package wb_port_arbiter_pkg;

  localparam int DEF_FIFO_DEPTH   = 2;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int REG_AW           = 5;
  localparam int DATA_W           = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_ld_fifo.sv
// Holding buffer for load returns that lost the RF port. Entries can be
// invalidated by destination register; dead entries still occupy a slot
// and are popped later without producing a write.
module wb_ld_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  wb_req_t                i_push_req,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [REG_AW-1:0]      i_flush_rd,
  output logic                   o_head_live,
  output wb_req_t                o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);

  wb_req_t          r_mem [DEPTH];
  logic [DEPTH-1:0] r_live;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;

  // Payload storage; contents are don't-care until the live flag is set.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_push_req;
  end

  // Live flags: a push revives its slot, a younger pipeline write kills matches.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_live <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_push && (r_wptr == PW'(i)))
          r_live[i] <= 1'b1;
        else if (i_flush && (r_mem[i].rd == i_flush_rd))
          r_live[i] <= 1'b0;
      end
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PW'(1);
      if (i_pop)  r_rptr <= r_rptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head      = r_mem[r_rptr];
  assign o_head_live = r_live[r_rptr];
  assign o_count     = r_count;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the pipeline WB stage
// and asynchronous load returns. The pipeline has priority; loads that lose
// are buffered and forced out with a one-cycle pipeline stall if starved.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pipe_we,
  input  logic [4:0]                  pipe_rd,
  input  logic [31:0]                 pipe_data,
  input  logic                        ld_valid,
  input  logic [4:0]                  ld_rd,
  input  logic [31:0]                 ld_data,
  output logic                        ld_ready,
  output logic                        rf_we,
  output logic [4:0]                  rf_waddr,
  output logic [31:0]                 rf_wdata,
  output logic                        pipe_stall,
  output logic [$clog2(FIFO_DEPTH):0] pend_cnt
);

  localparam int            CW          = $clog2(FIFO_DEPTH) + 1;
  localparam int            SW          = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);

  arb_state_t    r_state;
  logic [SW-1:0] r_starve;
  logic          r_rf_we;
  logic [4:0]    r_rf_waddr;
  logic [31:0]   r_rf_wdata;
  logic          r_pipe_stall;

  logic          w_ld_acc, w_pipe_wr, w_ld_keep, w_ld_clash;
  logic          w_push, w_pop, w_flush, w_head_live, w_sel_we, w_starve_hit;
  wb_req_t       w_head, w_sel, w_ld_req, w_pipe_req;
  logic [CW-1:0] w_count, w_cnt_after;
  logic [SW-1:0] w_starve_inc;

  assign w_ld_req     = '{rd: ld_rd, data: ld_data};
  assign w_pipe_req   = '{rd: pipe_rd, data: pipe_data};
  assign ld_ready     = (w_count < CW'(FIFO_DEPTH));
  assign w_ld_acc     = ld_valid & ld_ready;
  assign w_pipe_wr    = pipe_we & (pipe_rd != 5'd0);
  // x0 loads are accepted but never need a slot or a write.
  assign w_ld_keep    = w_ld_acc & (ld_rd != 5'd0);
  assign w_ld_clash   = w_pipe_wr & (ld_rd == pipe_rd);
  assign w_starve_inc = r_starve + SW'(1);
  assign w_starve_hit = (w_starve_inc >= STARVE_LAST);
  assign w_cnt_after  = w_count + CW'(w_push) - CW'(w_pop);

  wb_ld_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_req  (w_ld_req),
    .i_pop       (w_pop),
    .i_flush     (w_flush),
    .i_flush_rd  (pipe_rd),
    .o_head_live (w_head_live),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  // Pick this cycle's RF writer and the buffer push/pop/invalidate controls.
  always_comb begin
    w_push   = 1'b0;
    w_pop    = 1'b0;
    w_flush  = 1'b0;
    w_sel_we = 1'b0;
    w_sel    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_pipe_wr) begin
          w_sel_we = 1'b1;
          w_sel    = w_pipe_req;
          w_push   = w_ld_keep & ~w_ld_clash;
        end else if (w_ld_keep) begin
          w_sel_we = 1'b1;
          w_sel    = w_ld_req;
        end
      end
      ST_PEND: begin
        w_push = w_ld_keep & ~w_ld_clash;
        if (w_pipe_wr) begin
          w_flush  = 1'b1;
          w_sel_we = 1'b1;
          w_sel    = w_pipe_req;
        end else begin
          w_pop    = 1'b1;
          w_sel_we = w_head_live;
          w_sel    = w_head;
        end
      end
      ST_DRAIN: begin
        // The stalled pipeline re-presents its write, so it is ignored here.
        w_push   = w_ld_keep;
        w_pop    = 1'b1;
        w_sel_we = w_head_live;
        w_sel    = w_head;
      end
      default: ;
    endcase
  end

  // State, starvation counter and registered RF/stall outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_starve     <= '0;
      r_rf_we      <= 1'b0;
      r_rf_waddr   <= '0;
      r_rf_wdata   <= '0;
      r_pipe_stall <= 1'b0;
    end else begin
      r_rf_we      <= w_sel_we;
      r_rf_waddr   <= w_sel.rd;
      r_rf_wdata   <= w_sel.data;
      r_pipe_stall <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_starve <= '0;
          if (w_push) r_state <= ST_PEND;
        end
        ST_PEND: begin
          if (w_pipe_wr) begin
            r_starve <= w_starve_inc;
            if (w_starve_hit) begin
              r_state      <= ST_DRAIN;
              r_pipe_stall <= 1'b1;
            end
          end else begin
            r_starve <= '0;
            r_state  <= (w_cnt_after != '0) ? ST_PEND : ST_IDLE;
          end
        end
        ST_DRAIN: begin
          r_starve <= '0;
          r_state  <= (w_cnt_after != '0) ? ST_PEND : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rf_we      = r_rf_we;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = r_rf_wdata;
  assign pipe_stall = r_pipe_stall;
  assign pend_cnt   = w_count;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table, hand-written starvation and
// reset sequences, then random traffic checked against a queue-based model.
module tb_wb_port_arbiter;

  localparam int FD = 2;
  localparam int SL = 4;
  localparam int CW = $clog2(FD) + 1;
  localparam int NV = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          pipe_we;
  logic [4:0]    pipe_rd;
  logic [31:0]   pipe_data;
  logic          ld_valid;
  logic [4:0]    ld_rd;
  logic [31:0]   ld_data;
  logic          ld_ready;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic          pipe_stall;
  logic [CW-1:0] pend_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.FIFO_DEPTH(FD), .STARVE_LIMIT(SL)) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_we    (pipe_we),
    .pipe_rd    (pipe_rd),
    .pipe_data  (pipe_data),
    .ld_valid   (ld_valid),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .pipe_stall (pipe_stall),
    .pend_cnt   (pend_cnt)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          live;
  } ent_t;

  ent_t        m_q[$];
  int          m_wait = 0;   // pipeline writes since the oldest load last moved
  bit          m_drain = 0;  // current cycle is a forced drain
  bit          e_we;
  logic [4:0]  e_rd;
  logic [31:0] e_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit pw, input logic [4:0] prd, input logic [31:0] pd,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ldat);
    bit   acc, keep, pwr, nxt;
    ent_t h;
    e_we = 0; e_rd = '0; e_data = '0;
    if (!r) begin
      m_q.delete();
      m_wait  = 0;
      m_drain = 0;
      return;
    end
    acc  = lv && (m_q.size() < FD);
    keep = acc && (lrd != 0);
    pwr  = pw && (prd != 0);
    nxt  = 0;
    if (m_drain) begin
      h = m_q.pop_front();
      if (h.live) begin e_we = 1; e_rd = h.rd; e_data = h.data; end
      if (keep) m_q.push_back('{lrd, ldat, 1'b1});
      m_wait = 0;
    end else if (m_q.size() == 0) begin
      if (pwr) begin
        e_we = 1; e_rd = prd; e_data = pd;
        if (keep && lrd != prd) m_q.push_back('{lrd, ldat, 1'b1});
      end else if (keep) begin
        e_we = 1; e_rd = lrd; e_data = ldat;
      end
      m_wait = 0;
    end else if (pwr) begin
      foreach (m_q[i]) if (m_q[i].rd == prd) m_q[i].live = 0;
      e_we = 1; e_rd = prd; e_data = pd;
      if (keep && lrd != prd) m_q.push_back('{lrd, ldat, 1'b1});
      m_wait++;
      nxt = (m_wait >= SL - 1);
    end else begin
      h = m_q.pop_front();
      if (h.live) begin e_we = 1; e_rd = h.rd; e_data = h.data; end
      if (keep) m_q.push_back('{lrd, ldat, 1'b1});
      m_wait = 0;
    end
    m_drain = nxt;
  endtask

  // One clock: drive inputs, advance the model, compare just after the edge.
  task automatic step(input bit r, input bit pw, input logic [4:0] prd, input logic [31:0] pd,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ldat);
    rst = r; pipe_we = pw; pipe_rd = prd; pipe_data = pd;
    ld_valid = lv; ld_rd = lrd; ld_data = ldat;
    model(r, pw, prd, pd, lv, lrd, ldat);
    @(posedge clk);
    #1;
    chk("m_we", {31'd0, rf_we}, {31'd0, e_we});
    if (e_we || !r) begin
      chk("m_waddr", {27'd0, rf_waddr}, {27'd0, e_rd});
      chk("m_wdata", rf_wdata, e_data);
    end
    chk("m_stall", {31'd0, pipe_stall}, {31'd0, m_drain});
    chk("m_cnt", 32'(pend_cnt), 32'(m_q.size()));
    chk("m_ready", {31'd0, ld_ready}, {31'd0, (m_q.size() < FD)});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rst_n;
    bit          pw;
    logic [4:0]  prd;
    logic [31:0] pd;
    bit          lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    bit          e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    bit          e_stall;
    int          e_cnt;
  } vec_t;

  vec_t tbl [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pipe_writes;
    int stall_seen;

    // rst pw prd pd    lv lrd ldat           we rd  data           st cnt
    tbl[0]  = '{0, 0, 5'd0, 32'h0,   0, 5'd0,  32'h0,          0, 5'd0,  32'h0,          0, 0};
    tbl[1]  = '{1, 0, 5'd0, 32'h0,   1, 5'd5,  32'hDEADBEEF,   1, 5'd5,  32'hDEADBEEF,   0, 0};
    tbl[2]  = '{1, 1, 5'd3, 32'h11,  1, 5'd7,  32'h22,         1, 5'd3,  32'h11,         0, 1};
    tbl[3]  = '{1, 0, 5'd0, 32'h0,   0, 5'd0,  32'h0,          1, 5'd7,  32'h22,         0, 0};
    tbl[4]  = '{1, 1, 5'd1, 32'h100, 1, 5'd4,  32'h44,         1, 5'd1,  32'h100,        0, 1};
    tbl[5]  = '{1, 1, 5'd4, 32'h55,  0, 5'd0,  32'h0,          1, 5'd4,  32'h55,         0, 1};
    tbl[6]  = '{1, 0, 5'd0, 32'h0,   0, 5'd0,  32'h0,          0, 5'd0,  32'h0,          0, 0};
    tbl[7]  = '{1, 1, 5'd2, 32'hA,   1, 5'd10, 32'hAA,         1, 5'd2,  32'hA,          0, 1};
    tbl[8]  = '{1, 1, 5'd2, 32'hB,   1, 5'd11, 32'hBB,         1, 5'd2,  32'hB,          0, 2};
    tbl[9]  = '{1, 1, 5'd2, 32'hC,   1, 5'd12, 32'hCC,         1, 5'd2,  32'hC,          0, 2};
    tbl[10] = '{1, 0, 5'd0, 32'h0,   1, 5'd12, 32'hCC,         1, 5'd10, 32'hAA,         0, 1};
    tbl[11] = '{1, 0, 5'd0, 32'h0,   1, 5'd12, 32'hCC,         1, 5'd11, 32'hBB,         0, 1};
    tbl[12] = '{1, 0, 5'd0, 32'h0,   1, 5'd0,  32'hEE,         1, 5'd12, 32'hCC,         0, 0};
    tbl[13] = '{1, 0, 5'd0, 32'h0,   1, 5'd0,  32'hEE,         0, 5'd0,  32'h0,          0, 0};
    tbl[14] = '{1, 0, 5'd0, 32'h0,   0, 5'd0,  32'h0,          0, 5'd0,  32'h0,          0, 0};

    for (int i = 0; i < NV; i++) begin
      step(tbl[i].rst_n, tbl[i].pw, tbl[i].prd, tbl[i].pd, tbl[i].lv, tbl[i].lrd, tbl[i].ldat);
      chk($sformatf("t%0d_we", i), {31'd0, rf_we}, {31'd0, tbl[i].e_we});
      if (tbl[i].e_we || !tbl[i].rst_n) begin
        chk($sformatf("t%0d_waddr", i), {27'd0, rf_waddr}, {27'd0, tbl[i].e_rd});
        chk($sformatf("t%0d_wdata", i), rf_wdata, tbl[i].e_data);
      end
      chk($sformatf("t%0d_stall", i), {31'd0, pipe_stall}, {31'd0, tbl[i].e_stall});
      chk($sformatf("t%0d_cnt", i), 32'(pend_cnt), 32'(tbl[i].e_cnt));
      chk($sformatf("t%0d_ready", i), {31'd0, ld_ready}, {31'd0, (tbl[i].e_cnt < FD)});
      $display("vec %0d: we=%0b x%0d=%h stall=%0b cnt=%0d ready=%0b",
               i, rf_we, rf_waddr, rf_wdata, pipe_stall, pend_cnt, ld_ready);
    end

    // Starvation: one buffered load behind a pipeline that writes every cycle.
    pipe_writes = 0;
    stall_seen  = 0;
    step(1, 1, 5'd1, 32'h1000, 1, 5'd9, 32'h99);
    for (int k = 1; k <= 8 && stall_seen == 0; k++) begin
      if (rf_we && rf_waddr == 5'd1) pipe_writes++;
      if (pipe_stall) stall_seen = k;
      if (stall_seen == 0) step(1, 1, 5'd1, 32'h1000 + 32'(k), 0, 5'd0, 32'h0);
    end
    chk("starve_pipe_writes", 32'(pipe_writes), 32'd4);
    chk("starve_stall_cycle", 32'(stall_seen), 32'd4);
    step(1, 1, 5'd1, 32'h2000, 0, 5'd0, 32'h0);
    chk("drain_waddr", {27'd0, rf_waddr}, 32'd9);
    chk("drain_wdata", rf_wdata, 32'h99);
    chk("drain_stall_once", {31'd0, pipe_stall}, 32'd0);
    chk("drain_cnt", 32'(pend_cnt), 32'd0);
    $display("starve: %0d pipeline writes, stall on step %0d, drained x%0d=%h",
             pipe_writes, stall_seen, rf_waddr, rf_wdata);

    // Reset in the middle of a drain with two loads buffered.
    step(1, 1, 5'd1, 32'h3000, 1, 5'd9,  32'h91);
    step(1, 1, 5'd2, 32'h3001, 1, 5'd10, 32'h92);
    step(1, 1, 5'd2, 32'h3002, 0, 5'd0,  32'h0);
    step(1, 1, 5'd2, 32'h3003, 0, 5'd0,  32'h0);
    chk("pre_rst_stall", {31'd0, pipe_stall}, 32'd1);
    chk("pre_rst_cnt", 32'(pend_cnt), 32'd2);
    step(0, 1, 5'd2, 32'h3003, 1, 5'd11, 32'h93);
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_stall", {31'd0, pipe_stall}, 32'd0);
    chk("rst_cnt", 32'(pend_cnt), 32'd0);
    step(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("post_rst_ready", {31'd0, ld_ready}, 32'd1);
    chk("post_rst_we", {31'd0, rf_we}, 32'd0);
    step(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("post_rst_we2", {31'd0, rf_we}, 32'd0);
    $display("reset-in-drain: we=%0b cnt=%0d ready=%0b", rf_we, pend_cnt, ld_ready);

    // Random traffic against the model; small rd range forces ordering clashes.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(99) != 0),
           ($urandom_range(9) < 6), 5'($urandom_range(7)), $urandom(),
           ($urandom_range(1) == 1), 5'($urandom_range(7)), $urandom());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
